led_pattern_master: RTL
=======================

LED_PATTERN_MASTER -- requirements
Module: led_pattern_master

Interface
REQ-001 SHALL have parameter DIV_WIDTH, default 24, width of prescaler and div input.
REQ-002 SHALL have parameter TARGET_ADDR, default 2'd0, Avalon address of the downstream LED PIO data register.
REQ-003 SHALL use one clock, clk; reset is reset, asynchronous, active-high.
REQ-004 Ports SHALL be as follows:
- clk  in  1  system clock
- reset  in  1  async active-high reset
- enable  in  1  prescaler run enable
- mode  in  2  00 rotate-left, 01 rotate-right, 10 bounce, 11 binary count
- div  in  DIV_WIDTH  tick period minus 1
- clear_overrun  in  1  clears overrun
- avm_address  out  2  Avalon-MM master address, constant TARGET_ADDR
- avm_chipselect  out  1  write request
- avm_write_n  out  1  active-low write, equals ~avm_chipselect
- avm_writedata  out  32  {24'b0, next pattern}
- avm_waitrequest  in  1  slave stall
- pattern  out  8  last committed pattern
- busy  out  1  high when state != IDLE
- overrun  out  1  sticky dropped-tick flag

Function
REQ-005 FSM states SHALL be INIT, IDLE, WRITE; all Avalon outputs SHALL be registered.
REQ-006 Prescaler cnt SHALL be held at 0 while enable=0; while enable=1: tick=1 when cnt>=div, then cnt<=0; otherwise cnt<=cnt+1.
REQ-007 div=0 SHALL give a tick every enabled cycle; lowering div below cnt SHALL give a tick on the next enabled cycle.
REQ-008 Next pattern nxt SHALL be computed from pattern at tick time: rotate-left {p[6:0],p[7]}; rotate-right {p[0],p[7:1]}; count p+1 mod 256 (0xFF->0x00).
REQ-009 Bounce SHALL use dir (reset=left): if left and p[7]=1, set dir=right and shift right; if right and p[0]=1, set dir=left and shift left; otherwise shift in dir with zero fill; a pattern of 0x00 SHALL load 0x01.
REQ-010 Mode changes SHALL take effect at the next tick only.
REQ-011 INIT (entered on reset) SHALL assert chipselect=1, write_n=0, writedata=0x00000001 and hold until completion, then go to IDLE.
REQ-012 In IDLE, a tick at cycle N SHALL drive chipselect=1, writedata={24'b0,nxt} from cycle N+1 and enter WRITE.
REQ-013 A write SHALL complete at the first clk edge with chipselect=1 and avm_waitrequest=0; pattern<=writedata[7:0] on that edge.
REQ-014 writedata and address SHALL stay stable while waitrequest=1.
REQ-015 A tick on the completion cycle SHALL start the next write back-to-back (chipselect stays 1), using nxt computed from the just-committed value; no overrun.
REQ-016 A tick in WRITE or INIT while waitrequest=1 SHALL be dropped and set overrun=1.
REQ-017 clear_overrun=1 SHALL clear overrun next cycle; a simultaneous dropped tick SHALL win (overrun stays 1).
REQ-018 enable going low SHALL NOT abort an in-progress write.

Reset
REQ-019 While reset=1: state=INIT, cnt=0, dir=left, pattern=0x01, overrun=0, and on reset assertion avm_chipselect=0, avm_write_n=1, avm_writedata=0; mid-write reset SHALL abort immediately.
REQ-020 On the first edge after reset deasserts, the INIT write SHALL be presented (chipselect=1, writedata=0x00000001).

Verification
REQ-021 Release reset, waitrequest=0 -> one write of 0x00000001 to address 0, then busy=0, pattern=0x01.
REQ-022 mode=00, div=3, enable=1, waitrequest=0 -> writes every 4 cycles, data 0x02,0x04,...,0x80,0x01; no overrun.
REQ-023 mode=10 from pattern 0x40 -> 0x80,0x40,...,0x01,0x02; mode=11 from 0xFE -> 0xFF,0x00.
REQ-024 div=3, waitrequest held 10 cycles -> writedata stable, pattern unchanged, overrun=1; after release pattern updates; clear_overrun -> 0.
REQ-025 div=0, waitrequest=0 -> chipselect held continuously, one new pattern per cycle, overrun=0.
REQ-026 Assert reset during WRITE with waitrequest=1 -> chipselect=0 with no clock edge; after release, INIT write of 0x01.

Source files
------------

// File: rtl/led_pattern_master.sv
// led_pattern_master: prescaled LED pattern sequencer that pushes each new
// pattern to a downstream PIO over an Avalon-MM write master.
module led_pattern_master #(
    parameter int         DIV_WIDTH   = 24,
    parameter logic [1:0] TARGET_ADDR = 2'd0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [1:0]           mode,
    input  logic [DIV_WIDTH-1:0] div,
    input  logic                 clear_overrun,
    output logic [1:0]           avm_address,
    output logic                 avm_chipselect,
    output logic                 avm_write_n,
    output logic [31:0]          avm_writedata,
    input  logic                 avm_waitrequest,
    output logic [7:0]           pattern,
    output logic                 busy,
    output logic                 overrun
);
    typedef enum logic [1:0] {INIT, IDLE, WRITE} state_t;
    state_t               state;
    logic [DIV_WIDTH-1:0] cnt;
    logic                 left, tick, done, start, bounce_left;
    logic [7:0]           base, bounce, nxt;

    assign tick  = enable && cnt >= div;
    assign done  = avm_chipselect && !avm_waitrequest;
    assign start = tick && (state == IDLE || done);
    // a back-to-back write steps from the value being committed this cycle
    assign base        = done ? avm_writedata[7:0] : pattern;
    assign bounce_left = (base == 8'h00) ? left : left ? !base[7] : base[0];
    assign bounce      = (base == 8'h00) ? 8'h01 : bounce_left ? {base[6:0], 1'b0} : {1'b0, base[7:1]};
    assign nxt = mode == 2'b00 ? {base[6:0], base[7]} :
                 mode == 2'b01 ? {base[0], base[7:1]} :
                 mode == 2'b10 ? bounce : base + 8'd1;
    assign busy        = state != IDLE;
    assign avm_address = TARGET_ADDR;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= INIT;
            cnt            <= '0;
            left           <= 1'b1;
            pattern        <= 8'h01;
            overrun        <= 1'b0;
            avm_chipselect <= 1'b0;
            avm_write_n    <= 1'b1;
            avm_writedata  <= '0;
        end else begin
            cnt     <= (!enable || tick) ? '0 : cnt + 1'b1;
            overrun <= (tick && busy && avm_waitrequest) || (overrun && !clear_overrun);
            if (done)
                pattern <= avm_writedata[7:0];
            if (start) begin
                state          <= WRITE;
                avm_chipselect <= 1'b1;
                avm_write_n    <= 1'b0;
                avm_writedata  <= {24'b0, nxt};
                if (mode == 2'b10)
                    left <= bounce_left;
            end else if (done) begin
                state          <= IDLE;
                avm_chipselect <= 1'b0;
                avm_write_n    <= 1'b1;
            end else if (state == INIT && !avm_chipselect) begin
                avm_chipselect <= 1'b1;
                avm_write_n    <= 1'b0;
                avm_writedata  <= 32'd1;
            end
        end
    end
endmodule
